// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: Moore serial pattern detector (KMP transitions) with saturating match counter.
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             w,
    input  logic             en,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int SW = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);

    logic [SW-1:0]    state, nxt;
    logic [CNT_W-1:0] cnt_nxt;

    function automatic logic pat(input int i);
        return 1'(PATTERN >> (PAT_LEN - 1 - i));
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic logic [SW-1:0] step(input int k, input logic b);
        int   r;
        logic ok;
        logic s;
        r = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            ok = (j <= k + 1);
            for (int t = 0; t < j; t++) begin
                s  = (k + 1 - j + t == k) ? b : pat(k + 1 - j + t);
                ok = ok && (s == pat(t));
            end
            if (ok) r = j;
        end
        return SW'(r);
    endfunction

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state     <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            state     <= nxt;
            match_cnt <= cnt_nxt;
            cnt_sat   <= &cnt_nxt;
        end
    end

    // Encodings above MATCH match no k and fall back to S0.
    always_comb begin
        nxt = state;
        if (en) begin
            nxt = '0;
            for (int k = 0; k <= PAT_LEN; k++)
                if (state == SW'(k)) nxt = step((k == PAT_LEN && !OVERLAP) ? 0 : k, w);
        end
    end

    always_comb begin
        z       = (state == MATCH);
        cnt_nxt = clear ? '0
                : (en && nxt == MATCH && !(&match_cnt)) ? match_cnt + CNT_W'(1)
                : match_cnt;
    end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed vectors over several parameterisations, scoreboard-checked.
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic Reset = 1'b0, w = 1'b0, en = 1'b0, clear = 1'b0;
    logic [4:0] zv, sv;
    logic [7:0] cv [5];
    logic [1:0] c3;

    typedef struct {
        int         id;
        logic       z;
        logic [7:0] c;
        logic       s;
        int         n;
    } exp_t;

    exp_t sb[$];
    exp_t x;
    int checks = 0, errors = 0, nvec = 0;

    always #5 clk = ~clk;

    seq_pattern_detector d0 (.clk(clk), .Reset(Reset), .w(w), .en(en), .clear(clear),
                             .z(zv[0]), .match_cnt(cv[0]), .cnt_sat(sv[0]));
    seq_pattern_detector #(.OVERLAP(1'b0)) d1 (.clk(clk), .Reset(Reset), .w(w), .en(en), .clear(clear),
                             .z(zv[1]), .match_cnt(cv[1]), .cnt_sat(sv[1]));
    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1101)) d2 (.clk(clk), .Reset(Reset), .w(w), .en(en),
                             .clear(clear), .z(zv[2]), .match_cnt(cv[2]), .cnt_sat(sv[2]));
    seq_pattern_detector #(.CNT_W(2)) d3 (.clk(clk), .Reset(Reset), .w(w), .en(en), .clear(clear),
                             .z(zv[3]), .match_cnt(c3), .cnt_sat(sv[3]));
    seq_pattern_detector #(.PAT_LEN(1), .PATTERN(1'b0)) d4 (.clk(clk), .Reset(Reset), .w(w), .en(en),
                             .clear(clear), .z(zv[4]), .match_cnt(cv[4]), .cnt_sat(sv[4]));

    assign cv[3] = {6'b0, c3};

    // Drive one edge and queue the outputs the chosen instance must show after it.
    task automatic v(input int id, input logic rst, input logic e, input logic b, input logic clr,
                     input logic ez, input logic [7:0] ec, input logic es);
        Reset = rst; en = e; w = b; clear = clr;
        @(posedge clk);
        #1;
        sb.push_back('{id, ez, ec, es, nvec});
        nvec++;
    endtask

    always @(negedge clk)
        while (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (zv[x.id] !== x.z || cv[x.id] !== x.c || sv[x.id] !== x.s) begin
                errors++;
                $display("FAIL vec%0d dut%0d: got z=%0b cnt=%0d sat=%0b, expected z=%0b cnt=%0d sat=%0b",
                         x.n, x.id, zv[x.id], cv[x.id], sv[x.id], x.z, x.c, x.s);
            end
        end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        // defaults, overlapping 101
        v(0, 0, 1, 1, 1, 0, 0, 0);
        v(0, 1, 1, 1, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0, 0);
        v(0, 1, 1, 1, 0, 1, 1, 0);
        v(0, 1, 1, 0, 0, 0, 1, 0);
        v(0, 1, 1, 1, 0, 1, 2, 0);
        // non-overlapping 101
        v(1, 0, 1, 0, 0, 0, 0, 0);
        v(1, 1, 1, 1, 0, 0, 0, 0);
        v(1, 1, 1, 0, 0, 0, 0, 0);
        v(1, 1, 1, 1, 0, 1, 1, 0);
        v(1, 1, 1, 0, 0, 0, 1, 0);
        v(1, 1, 1, 1, 0, 0, 1, 0);
        v(1, 1, 1, 1, 0, 0, 1, 0);
        v(1, 1, 1, 0, 0, 0, 1, 0);
        v(1, 1, 1, 1, 0, 1, 2, 0);
        // 1101 overlapping
        v(2, 0, 1, 1, 0, 0, 0, 0);
        v(2, 1, 1, 1, 0, 0, 0, 0);
        v(2, 1, 1, 1, 0, 0, 0, 0);
        v(2, 1, 1, 0, 0, 0, 0, 0);
        v(2, 1, 1, 1, 0, 1, 1, 0);
        v(2, 1, 1, 1, 0, 0, 1, 0);
        v(2, 1, 1, 0, 0, 0, 1, 0);
        v(2, 1, 1, 1, 0, 1, 2, 0);
        // enable gating
        v(0, 0, 1, 0, 0, 0, 0, 0);
        v(0, 1, 1, 1, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0, 0, 0);
        v(0, 1, 1, 1, 0, 1, 1, 0);
        v(0, 1, 0, 0, 0, 1, 1, 0);
        v(0, 1, 0, 1, 0, 1, 1, 0);
        // reset mid-pattern discards progress and overrides en/w
        v(0, 0, 1, 0, 0, 0, 0, 0);
        v(0, 1, 1, 1, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, 0);
        v(0, 1, 1, 1, 0, 0, 0, 0);
        // 2-bit counter saturation and clear
        v(3, 0, 1, 0, 0, 0, 0, 0);
        v(3, 1, 1, 1, 0, 0, 0, 0);
        v(3, 1, 1, 0, 0, 0, 0, 0);
        v(3, 1, 1, 1, 0, 1, 1, 0);
        v(3, 1, 1, 0, 0, 0, 1, 0);
        v(3, 1, 1, 1, 0, 1, 2, 0);
        v(3, 1, 1, 0, 0, 0, 2, 0);
        v(3, 1, 1, 1, 0, 1, 3, 1);
        v(3, 1, 1, 0, 0, 0, 3, 1);
        v(3, 1, 1, 1, 0, 1, 3, 1);
        v(3, 1, 1, 0, 0, 0, 3, 1);
        v(3, 1, 1, 1, 0, 1, 3, 1);
        v(3, 1, 1, 0, 0, 0, 3, 1);
        v(3, 1, 1, 1, 1, 1, 0, 0);
        v(3, 1, 1, 0, 0, 0, 0, 0);
        // single-bit pattern 0
        v(4, 0, 1, 0, 0, 0, 0, 0);
        v(4, 1, 1, 0, 0, 1, 1, 0);
        v(4, 1, 1, 0, 0, 1, 2, 0);
        v(4, 1, 1, 1, 0, 0, 2, 0);
        v(4, 1, 1, 0, 0, 1, 3, 0);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
